// File: rtl/menu_controller.sv
// ---------------------------------------------------------------------------
// menu_controller
//   Main-menu controller for the fighting game. Draws NUM_ITEMS stacked
//   boxes, moves a wrapping cursor with the up/down keys, blinks the
//   highlighted entry, runs a pre-game countdown after select and fires a
//   one-cycle start_game pulse into the game core. The controller returns to
//   the menu when the game core raises return_menu.
//
// Ports
//   clk               system / pixel clock
//   reset             asynchronous, active-high reset
//   video_on          visible-area flag from the VGA timing generator
//   x, y              current pixel coordinates (10 bit)
//   key_up/down/select/back  debounced active-high key levels
//   return_menu       level from game core requesting the menu
//   vga_r/g/b         registered RGB332 colour (3/3/2 bit)
//   sel_index         current cursor position
//   countdown_digit   remaining seconds, 0 outside the countdown
//   in_menu_state     high while in MENU or COUNTDOWN
//   start_game        one-cycle pulse on entry to RUN
// ---------------------------------------------------------------------------
module menu_controller #(
    parameter int unsigned NUM_ITEMS      = 4,
    parameter int unsigned MENU_LEFT      = 200,
    parameter int unsigned MENU_TOP       = 120,
    parameter int unsigned ITEM_W         = 240,
    parameter int unsigned ITEM_H         = 40,
    parameter int unsigned ITEM_GAP       = 16,
    parameter int unsigned BLINK_DIV      = 12_500_000,
    parameter int unsigned TICKS_PER_SEC  = 25_000_000,
    parameter int unsigned COUNTDOWN_SECS = 3,
    localparam int IDX_W = (NUM_ITEMS <= 2) ? 1 : $clog2(NUM_ITEMS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             video_on,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_select,
    input  logic             key_back,
    input  logic             return_menu,
    output logic [2:0]       vga_r,
    output logic [2:0]       vga_g,
    output logic [1:0]       vga_b,
    output logic [IDX_W-1:0] sel_index,
    output logic [3:0]       countdown_digit,
    output logic             in_menu_state,
    output logic             start_game
);

    localparam int BLINK_W = (BLINK_DIV <= 2) ? 1 : $clog2(BLINK_DIV);
    localparam int TICK_W  = (TICKS_PER_SEC <= 2) ? 1 : $clog2(TICKS_PER_SEC);

    localparam logic [7:0] C_BLACK  = 8'h00;
    localparam logic [7:0] C_WHITE  = 8'hFF;
    localparam logic [7:0] C_YELLOW = 8'hFC;
    localparam logic [7:0] C_GREEN  = 8'h1C;
    localparam logic [7:0] C_GREY   = 8'h92;
    localparam logic [7:0] C_BG     = 8'h03;

    typedef enum logic [1:0] {
        S_MENU,
        S_COUNTDOWN,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_up_prev;
    logic               r_down_prev;
    logic               r_select_prev;
    logic               r_back_prev;

    logic [IDX_W-1:0]   r_sel;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [TICK_W-1:0]  r_tick;
    logic [3:0]         r_digit;
    logic               r_start;
    logic [7:0]         r_rgb;

    logic               w_up_edge;
    logic               w_down_edge;
    logic               w_select_edge;
    logic               w_back_edge;
    logic               w_move;
    logic               w_tick_tc;
    logic               w_blink_tc;
    logic               w_in_box;
    logic               w_in_sel;
    logic               w_x_in;
    logic [31:0]        w_x32;
    logic [31:0]        w_y32;
    logic [7:0]         w_rgb_next;

    // Key edges; history registers reset high so a key held through reset
    // release does not register as a press.
    assign w_up_edge     = key_up     & ~r_up_prev;
    assign w_down_edge   = key_down   & ~r_down_prev;
    assign w_select_edge = key_select & ~r_select_prev;
    assign w_back_edge   = key_back   & ~r_back_prev;

    // Select wins over navigation; opposing up/down edges cancel.
    assign w_move = (r_state == S_MENU) && !w_select_edge && (w_up_edge ^ w_down_edge);

    assign w_tick_tc  = (r_tick == TICK_W'(TICKS_PER_SEC - 1));
    assign w_blink_tc = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_MENU;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_MENU: begin
                if (w_select_edge) begin
                    w_state_next = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                // Abort takes priority over a same-cycle terminal count.
                if (w_back_edge) begin
                    w_state_next = S_MENU;
                end else if (w_tick_tc && (r_digit == 4'd1)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (return_menu) begin
                    w_state_next = S_MENU;
                end
            end
            default: w_state_next = S_MENU;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_menu_state = 1'b1;
        if (r_state == S_RUN) begin
            in_menu_state = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: key history, cursor, blink, countdown, start pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_up_prev     <= 1'b1;
            r_down_prev   <= 1'b1;
            r_select_prev <= 1'b1;
            r_back_prev   <= 1'b1;
            r_sel         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_tick        <= '0;
            r_digit       <= '0;
            r_start       <= 1'b0;
        end else begin
            r_up_prev     <= key_up;
            r_down_prev   <= key_down;
            r_select_prev <= key_select;
            r_back_prev   <= key_back;

            if (w_move) begin
                if (w_up_edge) begin
                    r_sel <= (r_sel == '0) ? IDX_W'(NUM_ITEMS - 1) : r_sel - 1'b1;
                end else begin
                    r_sel <= (r_sel == IDX_W'(NUM_ITEMS - 1)) ? '0 : r_sel + 1'b1;
                end
            end

            // A move restarts the blink so the new highlight is visible at once.
            if (r_state == S_MENU) begin
                if (w_move) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= 1'b1;
                end else if (w_blink_tc) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt   <= r_blink_cnt + 1'b1;
                end
            end else if ((r_state == S_RUN) && return_menu) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end

            case (r_state)
                S_MENU: begin
                    if (w_select_edge) begin
                        r_digit <= 4'(COUNTDOWN_SECS);
                        r_tick  <= '0;
                    end
                end
                S_COUNTDOWN: begin
                    if (w_back_edge) begin
                        r_digit <= '0;
                        r_tick  <= '0;
                    end else if (w_tick_tc) begin
                        r_tick  <= '0;
                        r_digit <= r_digit - 4'd1;
                    end else begin
                        r_tick  <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_digit <= '0;
                end
            endcase

            r_start <= (r_state == S_COUNTDOWN) && (w_state_next == S_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Rendering: box hit test at 32-bit width so bounds near 1023 are safe
    // ------------------------------------------------------------------
    assign w_x32  = {22'd0, x};
    assign w_y32  = {22'd0, y};
    assign w_x_in = (w_x32 >= MENU_LEFT) && (w_x32 < MENU_LEFT + ITEM_W);

    always_comb begin
        w_in_box = 1'b0;
        w_in_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (w_x_in &&
                (w_y32 >= MENU_TOP + i * (ITEM_H + ITEM_GAP)) &&
                (w_y32 <  MENU_TOP + i * (ITEM_H + ITEM_GAP) + ITEM_H)) begin
                w_in_box = 1'b1;
                if (IDX_W'(i) == r_sel) begin
                    w_in_sel = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rgb_next = C_BG;
        if (!video_on || (r_state == S_RUN)) begin
            w_rgb_next = C_BLACK;
        end else if (w_in_sel) begin
            if (r_state == S_COUNTDOWN) begin
                w_rgb_next = C_GREEN;
            end else begin
                w_rgb_next = r_blink_phase ? C_WHITE : C_YELLOW;
            end
        end else if (w_in_box) begin
            w_rgb_next = C_GREY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign vga_r           = r_rgb[7:5];
    assign vga_g           = r_rgb[4:2];
    assign vga_b           = r_rgb[1:0];
    assign sel_index       = r_sel;
    assign countdown_digit = r_digit;
    assign start_game      = r_start;

endmodule

// File: tb/tb_menu_controller.sv
// ---------------------------------------------------------------------------
// tb_menu_controller
//   Directed self-checking bench for menu_controller with NUM_ITEMS=3,
//   TICKS_PER_SEC=10, BLINK_DIV=4, COUNTDOWN_SECS=3. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_menu_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       key_up;
    logic       key_down;
    logic       key_select;
    logic       key_back;
    logic       return_menu;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;
    logic [1:0] sel_index;
    logic [3:0] countdown_digit;
    logic       in_menu_state;
    logic       start_game;

    int n_checks = 0;
    int n_err    = 0;
    int seen_start;

    logic [7:0] rgb;
    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    menu_controller #(
        .NUM_ITEMS      (3),
        .TICKS_PER_SEC  (10),
        .BLINK_DIV      (4),
        .COUNTDOWN_SECS (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .video_on        (video_on),
        .x               (x),
        .y               (y),
        .key_up          (key_up),
        .key_down        (key_down),
        .key_select      (key_select),
        .key_back        (key_back),
        .return_menu     (return_menu),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .sel_index       (sel_index),
        .countdown_digit (countdown_digit),
        .in_menu_state   (in_menu_state),
        .start_game      (start_game)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0;
        key_up = 1'b0; key_down = 1'b0; key_select = 1'b0; key_back = 1'b0;
        return_menu = 1'b0;
        step(3);
        chk("rst_sel", 32'(sel_index), 0);
        chk("rst_digit", 32'(countdown_digit), 0);
        chk("rst_inmenu", 32'(in_menu_state), 1);
        chk("rst_start", 32'(start_game), 0);
        chk("rst_rgb", 32'(rgb), 32'h00);
        reset = 1'b0;
        step(1);

        // 1. wrap
        key_up = 1'b1; step(1); chk("up_wrap", 32'(sel_index), 2);
        key_up = 1'b0; step(1);
        key_down = 1'b1; step(1); chk("down_wrap", 32'(sel_index), 0);
        key_down = 1'b0; step(1);
        key_down = 1'b1; step(1); chk("down_inc", 32'(sel_index), 1);
        key_down = 1'b0; step(1);

        // 2a. simultaneous up/down
        key_up = 1'b1; key_down = 1'b1; step(1);
        chk("updown_nomove", 32'(sel_index), 1);
        key_up = 1'b0; key_down = 1'b0; step(1);

        // 5. rendering with a fresh blink reload on sel_index=1
        video_on = 1'b1; x = 10'd200; y = 10'd176;
        key_up = 1'b1; step(1); chk("render_up", 32'(sel_index), 0);
        key_up = 1'b0; step(1);
        key_down = 1'b1; step(1); chk("render_sel1", 32'(sel_index), 1);
        step(1); chk("rgb_white", 32'(rgb), 32'hFF);
        step(3); chk("rgb_white_last", 32'(rgb), 32'hFF);
        step(1); chk("rgb_yellow", 32'(rgb), 32'hFC);
        x = 10'd200; y = 10'd120; step(1); chk("rgb_box0_grey", 32'(rgb), 32'h92);
        x = 10'd199; y = 10'd120; step(1); chk("rgb_left_bg", 32'(rgb), 32'h03);
        x = 10'd200; y = 10'd160; step(1); chk("rgb_gap_bg", 32'(rgb), 32'h03);
        x = 10'd440; y = 10'd176; step(1); chk("rgb_right_bg", 32'(rgb), 32'h03);
        x = 10'd200; y = 10'd232; step(1); chk("rgb_box2_grey", 32'(rgb), 32'h92);
        x = 10'd200; y = 10'd272; step(1); chk("rgb_box2_below", 32'(rgb), 32'h03);
        video_on = 1'b0; x = 10'd200; y = 10'd176; step(1);
        chk("rgb_blank", 32'(rgb), 32'h00);
        video_on = 1'b1;
        key_down = 1'b0; step(1);

        // 2b/3. select + down together, then countdown to start
        key_select = 1'b1; key_down = 1'b1; step(1);
        chk("cd_enter_digit", 32'(countdown_digit), 3);
        chk("cd_enter_sel", 32'(sel_index), 1);
        chk("cd_enter_inmenu", 32'(in_menu_state), 1);
        key_select = 1'b0; key_down = 1'b0;
        step(1); chk("rgb_green", 32'(rgb), 32'h1C);
        step(8); chk("cd_digit3_last", 32'(countdown_digit), 3);
        step(1); chk("cd_digit2", 32'(countdown_digit), 2);
        step(10); chk("cd_digit1", 32'(countdown_digit), 1);
        step(9);
        chk("cd_prestart", 32'(start_game), 0);
        chk("cd_prestart_inmenu", 32'(in_menu_state), 1);
        step(1);
        chk("start_pulse", 32'(start_game), 1);
        chk("start_inmenu", 32'(in_menu_state), 0);
        chk("start_digit", 32'(countdown_digit), 0);
        step(1);
        chk("start_width", 32'(start_game), 0);
        chk("run_inmenu", 32'(in_menu_state), 0);
        chk("run_rgb", 32'(rgb), 32'h00);

        // 4. return from RUN, then abort a countdown
        return_menu = 1'b1; step(1);
        chk("ret_inmenu", 32'(in_menu_state), 1);
        chk("ret_sel", 32'(sel_index), 1);
        return_menu = 1'b0; step(1);
        chk("ret_rgb_white", 32'(rgb), 32'hFF);
        key_select = 1'b1; step(1);
        chk("abort_enter", 32'(countdown_digit), 3);
        key_select = 1'b0; step(10);
        chk("abort_digit2", 32'(countdown_digit), 2);
        key_back = 1'b1; step(1);
        chk("abort_digit", 32'(countdown_digit), 0);
        chk("abort_inmenu", 32'(in_menu_state), 1);
        chk("abort_sel", 32'(sel_index), 1);
        key_back = 1'b0;
        seen_start = 0;
        for (int i = 0; i < 35; i++) begin
            step(1);
            if (start_game) seen_start++;
        end
        chk("abort_no_start", 32'(seen_start), 0);
        chk("abort_stay_menu", 32'(countdown_digit), 0);

        // 6. select held through reset release
        key_select = 1'b1; reset = 1'b1; step(2);
        reset = 1'b0; step(3);
        chk("held_no_cd", 32'(countdown_digit), 0);
        chk("held_sel_rst", 32'(sel_index), 0);
        key_select = 1'b0; step(1);
        key_select = 1'b1; step(1);
        chk("repress_cd", 32'(countdown_digit), 3);
        key_select = 1'b0; step(3);

        // asynchronous reset mid-countdown takes effect without a clock edge
        #2 reset = 1'b1;
        #1;
        chk("async_rst_digit", 32'(countdown_digit), 0);
        chk("async_rst_inmenu", 32'(in_menu_state), 1);
        step(1);
        reset = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/menu_controller.md
# menu_controller

Parametrised main-menu controller for the DE1-SoC fighting game. It presents `NUM_ITEMS` selectable entries as stacked boxes on the VGA output and handles cursor navigation with wrap-around, blinking highlight and a pre-game countdown. It holds `in_menu_state` while active and issues a one-cycle `start_game` pulse into the game core. It sits between the VGA timing generator and the game-state logic, and returns to the menu on `return_menu`.

## Interface
- `NUM_ITEMS`, 4 — number of menu entries, legal range 2..8; `IDX_W = (NUM_ITEMS<=2)?1:$clog2(NUM_ITEMS)`.
- `MENU_LEFT`, 200 — x of box left edge.
- `MENU_TOP`, 120 — y of first box top edge.
- `ITEM_W`, 240 — box width in pixels.
- `ITEM_H`, 40 — box height in pixels.
- `ITEM_GAP`, 16 — vertical gap between boxes.
- `BLINK_DIV`, 12_500_000 — cycles per blink half-period.
- `TICKS_PER_SEC`, 25_000_000 — cycles per countdown step.
- `COUNTDOWN_SECS`, 3 — countdown start value, legal range 1..9.
- `clk` in 1 — system/pixel clock.
- `reset` in 1 — asynchronous, active-high reset.
- `video_on` in 1 — visible-area flag.
- `x`, `y` in 10 each — current pixel coordinates.
- `key_up`, `key_down`, `key_select`, `key_back` in 1 each — synchronised, debounced, active-high levels.
- `return_menu` in 1 — level from game core requesting return to menu.
- `vga_r` out 3, `vga_g` out 3, `vga_b` out 2 — registered RGB332 colour.
- `sel_index` out IDX_W — current cursor position.
- `countdown_digit` out 4 — remaining seconds; 0 outside COUNTDOWN.
- `in_menu_state` out 1 — high in MENU and COUNTDOWN.
- `start_game` out 1 — one-cycle pulse on entry to RUN.

## Operation
- **Reset values:** state=MENU, `sel_index`=0, `countdown_digit`=0, `in_menu_state`=1, `start_game`=0, RGB=0, blink phase=1, blink and tick counters=0.
- **Key history registers** reset to 1. A key held through reset release therefore produces no edge.
- **Edge detection:** an event is `key & !prev_key`, evaluated every cycle.
- **MENU state:**
  - up edge: `sel_index` decrements; 0 wraps to NUM_ITEMS-1.
  - down edge: `sel_index` increments; NUM_ITEMS-1 wraps to 0.
  - up and down edges in the same cycle: no move.
  - Any move reloads the blink counter to 0 and sets blink phase to 1.
  - select edge: go to COUNTDOWN, load `countdown_digit`=COUNTDOWN_SECS, clear tick counter. Select has priority over a same-cycle up/down edge; the cursor is unchanged.
  - back edge in MENU: ignored.
- **COUNTDOWN state:**
  - The tick counter counts 0..TICKS_PER_SEC-1. At terminal count the digit decrements.
  - If the digit is 1 at terminal count: go to RUN, `countdown_digit`=0, `start_game`=1 for exactly that cycle, `in_menu_state`=0.
  - back edge: return to MENU, `countdown_digit`=0, cursor kept. back has priority over a same-cycle terminal count.
  - up, down and select are ignored.
- **RUN state:**
  - All keys are ignored.
  - `return_menu`=1: go to MENU, `in_menu_state`=1, cursor kept, blink phase=1.
- **Blink:** the counter runs only in MENU. At count BLINK_DIV-1 it wraps to 0 and toggles the phase.
- **Rendering (per pixel, result registered):**
  - `video_on`=0: black 8'h00.
  - RUN: black. The game renderer owns the screen.
  - Box i occupies MENU_LEFT ≤ x < MENU_LEFT+ITEM_W and top_i ≤ y < top_i+ITEM_H, with top_i = MENU_TOP + i*(ITEM_H+ITEM_GAP).
  - Selected box in MENU: white 8'hFF when phase=1, yellow 8'hFC when phase=0.
  - Selected box in COUNTDOWN: green 8'h1C.
  - Unselected box: grey 8'h92.
  - Elsewhere: background dark blue 8'h03.
- **Arithmetic:** compare at 11 bits or wider so box bounds near 1023 never overflow.

## Timing
- RGB valid 1 clk after the x/y/video_on inputs that produced it.
- Key edge to `sel_index` update: 1 clk after the first cycle the key is sampled high.
- Select edge to `countdown_digit`=COUNTDOWN_SECS: 1 clk.
- Select edge to `start_game`: COUNTDOWN_SECS*TICKS_PER_SEC+1 clks. The pulse width is exactly 1 clk.
- `in_menu_state` falls in the same cycle `start_game` rises.
- Asynchronous reset mid-COUNTDOWN or mid-RUN forces all reset values immediately. No `start_game` pulse is emitted.

## Test plan
Benches use NUM_ITEMS=3, TICKS_PER_SEC=10, BLINK_DIV=4, COUNTDOWN_SECS=3.

1. **Reset and wrap:** reset, then 1 up edge -> `sel_index`=2. Then 2 down edges -> 0, then 1.
2. **Simultaneous keys:** up and down rise together -> `sel_index` unchanged. Select and down rise together -> COUNTDOWN with cursor unchanged.
3. **Countdown to start:** select at cycle T -> digit 3 at T+1, 2 at T+11, 1 at T+21. `start_game`=1 only at T+31, where `in_menu_state`=0 and digit=0.
4. **Abort and return:** back edge while digit=2 -> MENU, digit 0, no `start_game`. In RUN, `return_menu`=1 -> `in_menu_state`=1 next clk with cursor kept.
5. **Rendering:** `sel_index`=1, video_on=1.
   - x=200, y=176 (box 1) -> RGB 8'hFF one clk later, 8'hFC after 4 cycles of blink.
   - x=200, y=120 (box 0) -> 8'h92.
   - x=199, y=120 -> 8'h03.
   - video_on=0 -> 8'h00.
6. **Held key through reset:** key_select held high across reset release -> no COUNTDOWN entry. A release followed by a press -> COUNTDOWN.
